// File: rtl/clkdiv_prog.sv
// clkdiv_prog: programmable clock divider with selectable output polarity.
// Divide ratio N = DIV+1. Ratio and polarity changes are loaded into a
// shadow register and applied only at a period boundary (wrap), so the
// output never shows a truncated pulse.
// Optional feature macro: CLKDIV_STOP_EN. When it is defined, DIV=0 parks
// the output at INV_R. When it is undefined, a DIV_IN of 0 is clamped to 1.
module clkdiv_prog #(
    parameter int WIDTH   = 8,
    parameter int RST_DIV = 1,
    parameter bit RST_INV = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             INV_IN,
    output logic             Y,
    output logic             TICK,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_s;
    logic             inv_r;
    logic             inv_s;
    logic             pend;

    logic             wrap;
    logic [WIDTH:0]   high_len;
    logic [WIDTH-1:0] div_req;
    logic             stopped;
    logic             y_nxt;
    logic             tick_nxt;

    // Wrap detection, high-phase length, request sanitising and next outputs
    always_comb begin
        wrap     = (cnt == div_r);
        // (N+1)>>1 with N = DIV_R+1, kept at WIDTH+1 bits so N = 2^WIDTH fits
        high_len = ({1'b0, div_r} + (WIDTH+1)'(2)) >> 1;
`ifdef CLKDIV_STOP_EN
        div_req  = DIV_IN;
        stopped  = (div_r == '0);
`else
        div_req  = (DIV_IN == '0) ? WIDTH'(1) : DIV_IN;
        stopped  = 1'b0;
`endif
        y_nxt    = stopped ? inv_r : (({1'b0, cnt} < high_len) ^ inv_r);
        tick_nxt = !stopped && (cnt == '0);
    end

    // Counter, registered outputs and load/apply handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            div_r <= WIDTH'(RST_DIV);
            inv_r <= RST_INV;
            div_s <= WIDTH'(RST_DIV);
            inv_s <= RST_INV;
            pend  <= 1'b0;
            Y     <= RST_INV;
            TICK  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            Y    <= y_nxt;
            TICK <= tick_nxt;
            DONE <= 1'b0;
            if (LD) begin
                div_s <= div_req;
                inv_s <= INV_IN;
            end
            // A load arriving on the wrap cycle bypasses the shadow
            if (wrap && LD) begin
                div_r <= div_req;
                inv_r <= INV_IN;
                pend  <= 1'b0;
                DONE  <= 1'b1;
            end else if (wrap && pend) begin
                div_r <= div_s;
                inv_r <= inv_s;
                pend  <= 1'b0;
                DONE  <= 1'b1;
            end else if (LD) begin
                pend  <= 1'b1;
            end
        end
    end

    assign BUSY = pend;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: scoreboard bench for clkdiv_prog. A period-level reference
// model pushes the expected outputs for every edge; a monitor pops and
// compares one cycle-slot after each rising edge.
module tb_clkdiv_prog;
    localparam int WIDTH   = 8;
    localparam int RST_DIV = 1;
    localparam bit RST_INV = 1'b0;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             ld     = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             inv_in = 1'b0;
    logic             y, tick, busy, done;

    always #5 clk = ~clk;

    clkdiv_prog #(.WIDTH(WIDTH), .RST_DIV(RST_DIV), .RST_INV(RST_INV)) dut (
        .CLK(clk), .RST(rst), .LD(ld), .DIV_IN(div_in), .INV_IN(inv_in),
        .Y(y), .TICK(tick), .BUSY(busy), .DONE(done)
    );

    typedef struct {
        logic y;
        logic tick;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: position within the current period, active period
    // length and polarity, plus at most one pending request (last wins).
    int m_pos = 0;
    int m_n   = RST_DIV + 1;
    bit m_inv = RST_INV;
    bit m_pend = 1'b0;
    int m_pend_n = 0;
    bit m_pend_inv = 1'b0;

    function automatic int req_n(input int d);
`ifdef CLKDIV_STOP_EN
        return d + 1;
`else
        return (d == 0) ? 2 : d + 1;
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the edge
    task automatic step(input bit r, input bit l, input int d, input bit iv);
        exp_t e;
        @(negedge clk);
        rst    = r;
        ld     = l;
        div_in = d[WIDTH-1:0];
        inv_in = iv;
        if (r) begin
            m_pos  = 0;
            m_n    = RST_DIV + 1;
            m_inv  = RST_INV;
            m_pend = 1'b0;
            e.y = RST_INV; e.tick = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        end else begin
            if (m_n == 1) begin
                e.y    = m_inv;
                e.tick = 1'b0;
            end else begin
                e.y    = (m_pos < (m_n + 1) / 2) ^ m_inv;
                e.tick = (m_pos == 0);
            end
            e.done = 1'b0;
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (l) begin
                    m_n = req_n(d); m_inv = iv; m_pend = 1'b0; e.done = 1'b1;
                end else if (m_pend) begin
                    m_n = m_pend_n; m_inv = m_pend_inv; m_pend = 1'b0; e.done = 1'b1;
                end
            end else begin
                m_pos++;
                if (l) begin
                    m_pend = 1'b1; m_pend_n = req_n(d); m_pend_inv = iv;
                end
            end
            e.busy = m_pend;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("Y",    y,    e.y);
            chk("TICK", tick, e.tick);
            chk("BUSY", busy, e.busy);
            chk("DONE", done, e.done);
        end
    end

    initial begin
        int r, l, d, sel;
        bit iv;
        // Reset, then default divide-by-2
        repeat (3) step(1'b1, 1'b0, 0, 1'b0);
        idle(8);
        // N=4 requested mid-period
        idle(1);
        step(1'b0, 1'b1, 3, 1'b0);
        idle(14);
        // N=5, then N=256
        step(1'b0, 1'b1, 4, 1'b0);
        idle(16);
        step(1'b0, 1'b1, 255, 1'b0);
        idle(530);
        // Two loads before the wrap: last request wins
        step(1'b0, 1'b1, 2, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 6, 1'b0);
        idle(30);
        // Polarity change only, then reset mid-period
        step(1'b0, 1'b1, 6, 1'b1);
        idle(25);
        step(1'b0, 1'b1, 3, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 0, 1'b0);
        idle(10);
        // DIV=0 request, then restart with DIV=1
        step(1'b0, 1'b1, 0, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 0, 1'b1);
        idle(8);
        step(1'b0, 1'b1, 1, 1'b0);
        idle(10);
        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 299) == 0) ? 1 : 0;
            l   = ($urandom_range(0, 15) == 0) ? 1 : 0;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       d = 0;
                1:       d = 255;
                2:       d = $urandom_range(0, 255);
                default: d = $urandom_range(1, 9);
            endcase
            iv = 1'($urandom_range(0, 1));
            step(r[0], l[0], d, iv);
        end
        @(negedge clk);
        ld = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Parametrised, programmable clock divider with selectable output polarity. It is the sequential successor to the fixed clock inverter cells and is intended for local derived clocks and strobes in the gp12t3v3 library.
- Divides CLK by a runtime ratio and produces a registered, glitch-free output with near-50% duty.
- Ratio and polarity changes are requested through a load handshake and take effect only at a period boundary. Output pulses are therefore never truncated.

Parameters:
- WIDTH, 8, width of divide-ratio field. Ratio N = DIV+1, range 2..2^WIDTH.
- RST_DIV, 1, divide field loaded on reset (N=2). Must be in 1..2^WIDTH-1.
- RST_INV, 0, output polarity loaded on reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- LD  input  1  load request; sampled every cycle.
- DIV_IN  input  WIDTH  requested divide field; captured when LD=1.
- INV_IN  input  1  requested polarity; captured when LD=1.
- Y  output  1  divided clock, registered.
- TICK  output  1  one-cycle pulse on the first cycle of each output period.
- BUSY  output  1  a load is pending and not yet applied.
- DONE  output  1  one-cycle pulse on the cycle the pending load is applied.

Behaviour:
- Internal state: counter CNT[WIDTH-1:0], active DIV_R/INV_R, shadow DIV_S/INV_S, pending flag PEND.
- Reset (RST=1 at an edge):
  - CNT=0, DIV_R=RST_DIV, INV_R=RST_INV, PEND=0.
  - Y=RST_INV, TICK=0, BUSY=0, DONE=0.
  - Reset overrides LD in the same cycle. A pending load is discarded.
- Derived values:
  - N = DIV_R+1.
  - High phase H = (N+1)>>1, evaluated at WIDTH+1 bits with no overflow.
- Counting:
  - If CNT==DIV_R (wrap), CNT<=0. Otherwise CNT<=CNT+1.
- Output:
  - Y<=((CNT<H) ^ INV_R), so Y lags CNT by one cycle.
  - Without inversion Y is high for H cycles and low for N-H cycles.
  - Odd N gives the extra cycle to the high phase.
- TICK <= (CNT==0), same one-cycle latency as Y.
- Load handshake:
  - LD=1: DIV_S<=DIV_IN, INV_S<=INV_IN, PEND<=1.
  - BUSY=PEND, registered, so it is high from the cycle after LD.
  - LD while PEND=1 overwrites the shadow (last request wins). No error is raised.
- Apply:
  - At a wrap edge with PEND=1: DIV_R<=DIV_S, INV_R<=INV_S, PEND<=0, DONE<=1 for one cycle. The new ratio governs the period starting at CNT=0.
  - LD and wrap in the same cycle: the incoming DIV_IN/INV_IN are applied directly at that wrap. DONE pulses and PEND ends 0.
- Glitch-freedom:
  - DIV_R and INV_R never change except at a wrap.
  - A polarity change at a wrap can lengthen the current phase. It never yields a phase shorter than 1 cycle.
- DIV=0 requests are handled per the optional feature.

Optional Feature:
- Macro: CLKDIV_STOP_EN.
- Defined:
  - Applying DIV=0 stops the clock. CNT holds at 0, Y holds at INV_R (parked), and TICK=0.
  - A subsequent load is applied on the next edge, since a stopped divider is always at a wrap. DONE pulses and counting restarts at CNT=0.
- Undefined: a DIV_IN of 0 is clamped to 1 (N=2) when captured into DIV_S. There is no stop capability.

Test Plan:
- Reset, RST_DIV=1, INV=0 -> Y toggles 1,0,1,0; TICK on every second cycle; BUSY=DONE=0.
- LD DIV_IN=3, INV_IN=0 mid-period -> BUSY=1 until the current period ends; DONE pulses once; then Y pattern is 1,1,0,0 with period 4 and TICK every 4 cycles.
- LD DIV_IN=4 (N=5) -> Y 1,1,1,0,0 repeating. Then LD DIV_IN=255, WIDTH=8 (N=256) -> 128 high / 128 low, no counter overflow.
- Two LDs (DIV 2, then 6) before the wrap -> one DONE; ratio 7 is applied and ratio 3 never appears.
- LD INV_IN=1 with DIV unchanged -> inverted waveform starts at the boundary; no phase shorter than 1 cycle. Then RST mid-period -> Y=RST_INV, BUSY=0, DIV_R=RST_DIV on the next cycle.
- LD DIV_IN=0: with CLKDIV_STOP_EN -> Y parks at INV_R and TICK stops, then LD DIV_IN=1 -> restart and DONE the next cycle. Without the macro -> behaves as N=2.
